// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO bank: register group codes and word-count helper.
package gpio_pkg;

  localparam logic [2:0] GRP_DIR     = 3'd0;
  localparam logic [2:0] GRP_OUT     = 3'd1;
  localparam logic [2:0] GRP_IN      = 3'd2;
  localparam logic [2:0] GRP_OUT_SET = 3'd3;
  localparam logic [2:0] GRP_OUT_CLR = 3'd4;
  localparam logic [2:0] GRP_RISE_EN = 3'd5;
  localparam logic [2:0] GRP_FALL_EN = 3'd6;
  localparam logic [2:0] GRP_STAT    = 3'd7;

  function automatic int unsigned word_count(input int unsigned n, input int unsigned dw);
    return (n + dw - 1) / dw;
  endfunction

endpackage

// File: rtl/gpio_bank_if.sv
// Register access bus between the GPMC front end and the GPIO bank.
interface gpio_bank_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 16
);
  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output wr_en, rd_en, addr, wdata, input rdata);
  modport slave  (input wr_en, rd_en, addr, wdata, output rdata);
endinterface

// File: rtl/gpio_edge_sync.sv
// Pin synchroniser with a history flop; emits rise/fall pulses once armed after reset.
module gpio_edge_sync #(
  parameter int W           = 48,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] pin_i,
  output logic [W-1:0] sync_o,
  output logic [W-1:0] rise_o,
  output logic [W-1:0] fall_o
);

  localparam int ARM_CNT = SYNC_STAGES + 1;
  localparam int CW      = $clog2(ARM_CNT + 1);

  logic [W-1:0]  sync_q [SYNC_STAGES];
  logic [W-1:0]  prev_q;
  logic [CW-1:0] arm_q;
  logic          armed;

  // Edges stay masked until the reset zeros have flushed out of the pipeline.
  assign armed = (arm_q == CW'(ARM_CNT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q <= '0;
      arm_q  <= '0;
    end else begin
      sync_q[0] <= pin_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_q[SYNC_STAGES-1];
      if (!armed) arm_q <= arm_q + 1'b1;
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign rise_o = armed ? (sync_o & ~prev_q) : '0;
  assign fall_o = armed ? (~sync_o & prev_q) : '0;

endmodule

// File: rtl/gpio_bank.sv
// Parametrised GPIO bank: direction/output registers, atomic set/clear, synchronised
// inputs and edge-capture status with a level interrupt.
module gpio_bank
  import gpio_pkg::*;
#(
  parameter int NUM_PORTS   = 6,
  parameter int PORT_WIDTH  = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int WSEL_BITS   = 2,
  parameter int ADDR_WIDTH  = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  gpio_bank_if.slave                        bus,
  inout  wire [NUM_PORTS*PORT_WIDTH-1:0]    io,
  output logic                              irq
);

  localparam int N          = NUM_PORTS * PORT_WIDTH;
  localparam int WORDS_MAX  = 2 ** WSEL_BITS;
  localparam int NWORDS     = word_count(N, DATA_WIDTH);

  logic [2:0]            grp;
  logic [WSEL_BITS-1:0]  word;
  logic [N-1:0]          dir_q, dir_d, out_q, out_d;
  logic [N-1:0]          rise_en_q, rise_en_d, fall_en_q, fall_en_d;
  logic [N-1:0]          stat_q, stat_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  irq_q;
  logic [N-1:0]          sel, wbits, sync, rise, fall, rd_src;
  logic [DATA_WIDTH-1:0] word_view [WORDS_MAX];

  assign grp  = bus.addr[ADDR_WIDTH-1 -: 3];
  assign word = bus.addr[WSEL_BITS-1:0];

  gpio_edge_sync #(.W(N), .SYNC_STAGES(SYNC_STAGES)) u_edge (
    .clk    (clk),
    .rst    (rst),
    .pin_i  (io),
    .sync_o (sync),
    .rise_o (rise),
    .fall_o (fall)
  );

  // Per-pin word select, aligned write data and tri-state drive.
  for (genvar gi = 0; gi < N; gi++) begin : g_pin
    assign sel[gi]   = (word == WSEL_BITS'(gi / DATA_WIDTH));
    assign wbits[gi] = sel[gi] & bus.wdata[gi % DATA_WIDTH];
    assign io[gi]    = dir_q[gi] ? out_q[gi] : 1'bz;
  end

  // Read view of the selected group; bits beyond N or past the last word read 0.
  for (genvar gi = 0; gi < WORDS_MAX; gi++) begin : g_word
    for (genvar gj = 0; gj < DATA_WIDTH; gj++) begin : g_bit
      if (gi < NWORDS && gi * DATA_WIDTH + gj < N) begin : g_live
        assign word_view[gi][gj] = rd_src[gi*DATA_WIDTH+gj];
      end else begin : g_pad
        assign word_view[gi][gj] = 1'b0;
      end
    end
  end

  always_comb begin
    rd_src = '0;
    case (grp)
      GRP_DIR:     rd_src = dir_q;
      GRP_OUT:     rd_src = out_q;
      GRP_IN:      rd_src = sync;
      GRP_RISE_EN: rd_src = rise_en_q;
      GRP_FALL_EN: rd_src = fall_en_q;
      GRP_STAT:    rd_src = stat_q;
      default:     rd_src = '0;
    endcase
  end

  always_comb begin
    dir_d     = dir_q;
    out_d     = out_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    rdata_d   = bus.rd_en ? word_view[word] : '0;
    if (bus.wr_en) begin
      case (grp)
        GRP_DIR:     dir_d     = (dir_q & ~sel) | wbits;
        GRP_OUT:     out_d     = (out_q & ~sel) | wbits;
        GRP_OUT_SET: out_d     = out_q | wbits;
        GRP_OUT_CLR: out_d     = out_q & ~wbits;
        GRP_RISE_EN: rise_en_d = (rise_en_q & ~sel) | wbits;
        GRP_FALL_EN: fall_en_d = (fall_en_q & ~sel) | wbits;
        default:     ;
      endcase
    end
    // New edges are OR-ed in after the clear so a coincident event is never lost.
    stat_d = (stat_q & ~((bus.wr_en && grp == GRP_STAT) ? wbits : '0))
           | (rise & rise_en_q) | (fall & fall_en_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q     <= '0;
      out_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      stat_q    <= '0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      dir_q     <= dir_d;
      out_q     <= out_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      stat_q    <= stat_d;
      rdata_q   <= rdata_d;
      irq_q     <= |stat_q;
    end
  end

  assign bus.rdata = rdata_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank: register vector table plus edge/irq/reset sequences,
// run on a 6x8 bank and a 3x8 bank.
module tb_gpio_bank;
  import gpio_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gpio_bank_if #(.ADDR_WIDTH(5), .DATA_WIDTH(16)) bus_a ();
  gpio_bank_if #(.ADDR_WIDTH(5), .DATA_WIDTH(16)) bus_b ();

  wire  [47:0] io_a;
  wire  [23:0] io_b;
  logic [47:0] pin_oe, pin_val;
  logic [23:0] pin_oe_b, pin_val_b;
  logic        irq_a, irq_b;

  for (genvar gi = 0; gi < 48; gi++) begin : g_drv_a
    assign io_a[gi] = pin_oe[gi] ? pin_val[gi] : 1'bz;
  end
  for (genvar gi = 0; gi < 24; gi++) begin : g_drv_b
    assign io_b[gi] = pin_oe_b[gi] ? pin_val_b[gi] : 1'bz;
  end

  gpio_bank #(.NUM_PORTS(6), .PORT_WIDTH(8)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a), .io (io_a), .irq (irq_a)
  );
  gpio_bank #(.NUM_PORTS(3), .PORT_WIDTH(8)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b), .io (io_b), .irq (irq_b)
  );

  typedef struct {
    bit          dut;
    bit          wr;
    bit          rd;
    logic [4:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  vec_t vt[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(bit dut, bit wr, bit rd, logic [2:0] g, logic [1:0] w,
                              logic [15:0] d, logic [15:0] e);
    vec_t v;
    v.dut = dut; v.wr = wr; v.rd = rd; v.addr = {g, w}; v.wdata = d; v.exp = e;
    return v;
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  task automatic bus_idle();
    bus_a.wr_en = 1'b0; bus_a.rd_en = 1'b0; bus_a.addr = '0; bus_a.wdata = '0;
    bus_b.wr_en = 1'b0; bus_b.rd_en = 1'b0; bus_b.addr = '0; bus_b.wdata = '0;
  endtask

  // One bus access: drive on a falling edge, sample rdata on the next falling edge.
  task automatic bus_op(input bit dut, input bit wr, input bit rd, input logic [4:0] a,
                        input logic [15:0] d, output logic [15:0] q);
    @(negedge clk);
    if (dut) begin
      bus_b.wr_en = wr; bus_b.rd_en = rd; bus_b.addr = a; bus_b.wdata = d;
    end else begin
      bus_a.wr_en = wr; bus_a.rd_en = rd; bus_a.addr = a; bus_a.wdata = d;
    end
    @(negedge clk);
    q = dut ? bus_b.rdata : bus_a.rdata;
    bus_idle();
  endtask

  task automatic wr_a(input logic [2:0] g, input logic [1:0] w, input logic [15:0] d);
    logic [15:0] q;
    bus_op(1'b0, 1'b1, 1'b0, {g, w}, d, q);
  endtask

  task automatic rd_a(input string nm, input logic [2:0] g, input logic [1:0] w,
                      input logic [15:0] e);
    logic [15:0] q;
    bus_op(1'b0, 1'b0, 1'b1, {g, w}, 16'h0, q);
    check(nm, q, e);
  endtask

  initial begin
    logic [15:0] q;
    bus_idle();
    pin_oe    = '1;
    pin_val   = '1;
    pin_oe_b  = 24'h00FFFF;
    pin_val_b = 24'h005AA5;

    // Reset with pins high.
    repeat (3) @(negedge clk);
    check("reset rdata", bus_a.rdata, 16'h0);
    check("reset irq", {15'h0, irq_a}, 16'h0);
    pin_oe[7:0] = 8'h00;
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // Register vectors.
    vt.push_back(mk(0, 0, 1, GRP_STAT,    0, 16'h0,    16'h0000));
    vt.push_back(mk(0, 0, 1, GRP_STAT,    1, 16'h0,    16'h0000));
    vt.push_back(mk(0, 0, 1, GRP_STAT,    2, 16'h0,    16'h0000));
    vt.push_back(mk(0, 0, 1, GRP_DIR,     0, 16'h0,    16'h0000));
    vt.push_back(mk(0, 1, 0, GRP_DIR,     0, 16'h00FF, 16'h0));
    vt.push_back(mk(0, 1, 0, GRP_OUT,     0, 16'h00A5, 16'h0));
    vt.push_back(mk(0, 0, 1, GRP_DIR,     0, 16'h0,    16'h00FF));
    vt.push_back(mk(0, 0, 1, GRP_OUT,     0, 16'h0,    16'h00A5));
    vt.push_back(mk(0, 0, 1, GRP_IN,      0, 16'h0,    16'hFFA5));
    vt.push_back(mk(0, 1, 0, GRP_OUT,     1, 16'h0F0F, 16'h0));
    vt.push_back(mk(0, 1, 0, GRP_OUT_SET, 1, 16'h1000, 16'h0));
    vt.push_back(mk(0, 1, 0, GRP_OUT_CLR, 1, 16'h000F, 16'h0));
    vt.push_back(mk(0, 0, 1, GRP_OUT,     1, 16'h0,    16'h1F00));
    vt.push_back(mk(0, 0, 1, GRP_OUT_SET, 1, 16'h0,    16'h0000));
    vt.push_back(mk(0, 0, 1, GRP_OUT_CLR, 1, 16'h0,    16'h0000));
    vt.push_back(mk(0, 1, 0, GRP_DIR,     3, 16'hFFFF, 16'h0));
    vt.push_back(mk(0, 0, 1, GRP_DIR,     3, 16'h0,    16'h0000));
    vt.push_back(mk(0, 0, 1, GRP_IN,      3, 16'h0,    16'h0000));
    vt.push_back(mk(0, 1, 0, GRP_IN,      0, 16'h1234, 16'h0));
    vt.push_back(mk(0, 0, 1, GRP_IN,      0, 16'h0,    16'hFFA5));
    vt.push_back(mk(0, 1, 1, GRP_OUT,     0, 16'h005A, 16'h00A5));
    vt.push_back(mk(0, 0, 1, GRP_OUT,     0, 16'h0,    16'h005A));
    vt.push_back(mk(0, 1, 0, GRP_FALL_EN, 1, 16'hABCD, 16'h0));
    vt.push_back(mk(0, 0, 1, GRP_FALL_EN, 1, 16'h0,    16'hABCD));
    vt.push_back(mk(0, 1, 0, GRP_FALL_EN, 1, 16'h0000, 16'h0));
    vt.push_back(mk(0, 1, 0, GRP_RISE_EN, 2, 16'h0001, 16'h0));
    vt.push_back(mk(0, 0, 1, GRP_RISE_EN, 2, 16'h0,    16'h0001));
    vt.push_back(mk(1, 1, 0, GRP_DIR,     1, 16'hFFFF, 16'h0));
    vt.push_back(mk(1, 0, 1, GRP_DIR,     1, 16'h0,    16'h00FF));
    vt.push_back(mk(1, 1, 0, GRP_OUT,     2, 16'hFFFF, 16'h0));
    vt.push_back(mk(1, 0, 1, GRP_OUT,     2, 16'h0,    16'h0000));
    vt.push_back(mk(1, 1, 0, GRP_IN,      0, 16'hFFFF, 16'h0));
    vt.push_back(mk(1, 0, 1, GRP_IN,      0, 16'h0,    16'h5AA5));
    vt.push_back(mk(1, 0, 1, GRP_STAT,    3, 16'h0,    16'h0000));
    vt.push_back(mk(1, 0, 1, GRP_RISE_EN, 3, 16'h0,    16'h0000));

    foreach (vt[i]) begin
      bus_op(vt[i].dut, vt[i].wr, vt[i].rd, vt[i].addr, vt[i].wdata, q);
      if (vt[i].rd)
        check($sformatf("vec%0d dut%0d rd addr=%h", i, vt[i].dut, vt[i].addr), q, vt[i].exp);
      else
        $display("txn  vec%0d dut%0d wr addr=%h data=%h", i, vt[i].dut, vt[i].addr, vt[i].wdata);
    end

    // Driven pins carry OUT; undriven pins follow the external source.
    check("io[7:0] driven", {8'h0, io_a[7:0]}, 16'h005A);
    pin_val[15:8] = 8'h3C;
    repeat (4) @(negedge clk);
    rd_a("IN w0 external", GRP_IN, 0, 16'h3C5A);

    // Rising edge on pin 32: STAT after 3 edges, irq one edge later.
    pin_val[32] = 1'b0;
    repeat (6) @(negedge clk);
    rd_a("STAT w2 no fall", GRP_STAT, 2, 16'h0000);
    @(negedge clk);
    pin_val[32] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("rise irq cycle %0d", k), {15'h0, irq_a}, (k == 4) ? 16'h1 : 16'h0);
    end
    rd_a("STAT w2 rise", GRP_STAT, 2, 16'h0001);
    rd_a("IN w2", GRP_IN, 2, 16'hFFFF);

    // W1C coinciding with a new enabled edge: set wins.
    pin_val[32] = 1'b0;
    repeat (6) @(negedge clk);
    check("irq held", {15'h0, irq_a}, 16'h1);
    pin_val[32] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus_a.wr_en = 1'b1; bus_a.addr = {GRP_STAT, 2'd2}; bus_a.wdata = 16'h0001;
    @(negedge clk);
    bus_idle();
    check("collide irq t0", {15'h0, irq_a}, 16'h1);
    @(negedge clk);
    check("collide irq t1", {15'h0, irq_a}, 16'h1);
    rd_a("STAT w2 set wins", GRP_STAT, 2, 16'h0001);

    // Plain W1C: STAT clears, irq drops one cycle later.
    bus_op(1'b0, 1'b1, 1'b0, {GRP_STAT, 2'd2}, 16'h0001, q);
    check("w1c irq t0", {15'h0, irq_a}, 16'h1);
    @(negedge clk);
    check("w1c irq t1", {15'h0, irq_a}, 16'h0);
    rd_a("STAT w2 cleared", GRP_STAT, 2, 16'h0000);

    // Falling edge on pin 33; its rise is not enabled.
    wr_a(GRP_FALL_EN, 2, 16'h0002);
    pin_val[33] = 1'b0;
    repeat (5) @(negedge clk);
    rd_a("STAT w2 fall", GRP_STAT, 2, 16'h0002);
    check("fall irq", {15'h0, irq_a}, 16'h1);
    wr_a(GRP_STAT, 2, 16'h0002);
    pin_val[33] = 1'b1;
    repeat (5) @(negedge clk);
    rd_a("STAT w2 rise masked", GRP_STAT, 2, 16'h0000);
    check("irq after clear", {15'h0, irq_a}, 16'h0);

    // Reset mid-write while io[3] falls.
    wr_a(GRP_FALL_EN, 0, 16'hFFFF);
    @(negedge clk);
    bus_a.wr_en = 1'b1; bus_a.addr = {GRP_OUT_CLR, 2'd0}; bus_a.wdata = 16'h0008;
    #2;
    rst = 1'b1;
    pin_oe = '1;
    pin_val[15:0] = 16'h1234;
    @(negedge clk);
    bus_idle();
    check("rst rdata", bus_a.rdata, 16'h0);
    check("rst irq", {15'h0, irq_a}, 16'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("post-rst irq", {15'h0, irq_a}, 16'h0);
    rd_a("post-rst DIR w0", GRP_DIR, 0, 16'h0000);
    rd_a("post-rst OUT w0", GRP_OUT, 0, 16'h0000);
    rd_a("post-rst OUT w1", GRP_OUT, 1, 16'h0000);
    rd_a("post-rst FALL w0", GRP_FALL_EN, 0, 16'h0000);
    rd_a("post-rst RISE w2", GRP_RISE_EN, 2, 16'h0000);
    rd_a("post-rst STAT w0", GRP_STAT, 0, 16'h0000);
    rd_a("post-rst STAT w2", GRP_STAT, 2, 16'h0000);
    rd_a("post-rst IN w0", GRP_IN, 0, 16'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
